// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the parametrised sequence detector
package seq_det_pkg;
    localparam int PAT_MAX = 256;
    typedef enum logic {FILLING, ARMED} fill_state_t;
    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic logic [31:0] pat_sym(input logic [PAT_MAX-1:0] p, input int i, input int w);
        logic [PAT_MAX-1:0] s;
        s = p >> (i * w);
        return s[31:0] & ((32'd1 << w) - 32'd1);
    endfunction
endpackage

// File: rtl/sym_shift_reg.sv
// sym_shift_reg: SYM_W x DEPTH symbol history, entry 0 oldest, new symbol enters at DEPTH-1
// ports: clk, r (async reset), en (shift), clr (sync clear), d (symbol in), q (flattened history)
module sym_shift_reg #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic                   en,
    input  logic                   clr,
    input  logic [SYM_W-1:0]       d,
    output logic [DEPTH*SYM_W-1:0] q
);
    always_ff @(posedge clk or posedge r)
        if (r) q <= '0;
        else if (clr) q <= '0;
        else if (en) q <= {d, q[DEPTH*SYM_W-1:SYM_W]};
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: maskable, programmable DEPTH-symbol sequence detector with saturating match counter
// ports: clk, r (async reset), x/x_valid (symbol stream), pat/pat_mask (pattern, symbol 0 oldest),
//        overlap, clr (sync clear), z (match pulse), z_count (saturating), z_sat (counter at max)
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int SYM_W = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic [SYM_W-1:0]       x,
    input  logic                   x_valid,
    input  logic [DEPTH*SYM_W-1:0] pat,
    input  logic [DEPTH-1:0]       pat_mask,
    input  logic                   overlap,
    input  logic                   clr,
    output logic                   z,
    output logic [CNT_W-1:0]       z_count,
    output logic                   z_sat
);
    localparam int FILL_W = fill_w(DEPTH);
    localparam logic [CNT_W-1:0] CMAX = '1;
    logic [DEPTH*SYM_W-1:0] hist, nxt;
    logic [FILL_W-1:0] fill;
    fill_state_t state;
    logic hit, full_next, match;
    logic [CNT_W-1:0] cnt_nxt;
    sym_shift_reg #(.SYM_W(SYM_W), .DEPTH(DEPTH)) u_hist (
        .clk(clk), .r(r), .en(x_valid), .clr(clr), .d(x), .q(hist)
    );
    // compare against the history as it will be after this edge's shift
    assign nxt = {x, hist[DEPTH*SYM_W-1:SYM_W]};
    always_comb begin
        hit = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            if (pat_mask[i] && nxt[i*SYM_W +: SYM_W] != SYM_W'(pat_sym(PAT_MAX'(pat), i, SYM_W)))
                hit = 1'b0;
    end
    assign full_next = state == ARMED || fill == FILL_W'(DEPTH - 1);
    assign match = x_valid && !clr && full_next && hit;
    assign cnt_nxt = (match && z_count != CMAX) ? z_count + 1'b1 : z_count;
    always_ff @(posedge clk or posedge r) begin
        if (r || clr) begin
            fill    <= '0;
            state   <= FILLING;
            z       <= 1'b0;
            z_count <= '0;
            z_sat   <= 1'b0;
        end else begin
            z       <= match;
            z_count <= cnt_nxt;
            z_sat   <= cnt_nxt == CMAX;
            if (x_valid) begin
                if (match && !overlap) begin
                    fill  <= '0;
                    state <= FILLING;
                end else if (full_next) begin
                    fill  <= FILL_W'(DEPTH);
                    state <= ARMED;
                end else begin
                    fill  <= fill + 1'b1;
                end
            end
        end
    end
endmodule
